// File: rtl/word_serializer32.sv
// Parallel-to-serial converter: loads a WIDTH-bit word over valid/ready and streams it
// one bit per accepted cycle, flagging the final bit, with zero-bubble reload on the last bit.
module word_serializer32 #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             xfer;

    // The output end is always the bit presented on out_bit; shifting zero-fills behind it.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign shifted = {1'b0, shift_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load on the last-bit edge takes priority, keeping the block in SHIFT with no gap.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = in_data;
            cnt_d   = CNT_TOP;
            state_d = SHIFT;
        end else if (xfer) begin
            shift_d = shifted;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == SHIFT);
        out_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        out_last  = (state_q == SHIFT) && (cnt_q == '0);
        in_ready  = !reset && ((state_q == IDLE) || (out_last && out_ready));
        load      = in_valid && in_ready;
        xfer      = out_valid && out_ready;
    end

endmodule

// File: tb/tb_word_serializer32.sv
// Bench for word_serializer32: directed words, expected bits queued at issue and
// checked by independent monitors on both an MSB-first and an LSB-first instance.
module tb_word_serializer32;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid, in_ready, out_valid, out_ready, out_bit, out_last;
    logic [W-1:0] in_data;
    logic         in_valid0, in_ready0, out_valid0, out_ready0, out_bit0, out_last0;
    logic [W-1:0] in_data0;

    int checks = 0;
    int errors = 0;

    logic [1:0]   exp_q[$];
    logic [1:0]   exp0_q[$];
    logic [W-1:0] word_q[$];

    word_serializer32 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last)
    );

    word_serializer32 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_bit(out_bit0), .out_last(out_last0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {bit, last} for the i-th serial bit of word w
    function automatic logic [1:0] ebit(input logic [W-1:0] w, input bit msb, input int i);
        logic b;
        b = msb ? w[W-1-i] : w[i];
        return {b, (i == W - 1)};
    endfunction

    task automatic push1(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) exp_q.push_back(ebit(w, 1'b1, i));
        word_q.push_back(w);
    endtask

    task automatic load1(input logic [W-1:0] w, input bit hold);
        int n;
        bit acc;
        n = 0;
        push1(w);
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL load_timeout actual=no_accept required=accept word=%h", w);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp0_q.size() != 0) && n < 500) begin
            step();
            n++;
        end
        step();
        check("drain_q", W'(exp_q.size()), 0);
        check("drain_q0", W'(exp0_q.size()), 0);
    endtask

    // Monitor for the MSB-first instance: bit order, last flag, stall stability, whole word.
    initial begin
        logic         prev_stall, prev_bit, prev_last;
        logic [1:0]   e;
        logic [W-1:0] coll;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        prev_last  = 1'b0;
        coll       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                coll       = '0;
            end else begin
                if (prev_stall) begin
                    check("stall_bit", W'(out_bit), W'(prev_bit));
                    check("stall_last", W'(out_last), W'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit actual=%b required=none", out_bit);
                    end else begin
                        e = exp_q.pop_front();
                        check("bit", W'(out_bit), W'(e[1]));
                        check("last", W'(out_last), W'(e[0]));
                        coll = {coll[W-2:0], out_bit};
                        if (out_last && word_q.size() != 0) begin
                            check("word", coll, word_q.pop_front());
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_bit   = out_bit;
                prev_last  = out_last;
            end
        end
    end

    // Monitor for the LSB-first instance.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid0 && out_ready0) begin
                if (exp0_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit0 actual=%b required=none", out_bit0);
                end else begin
                    e = exp0_q.pop_front();
                    check("bit0", W'(out_bit0), W'(e[1]));
                    check("last0", W'(out_last0), W'(e[0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  vcount, mism, n;
        bit  acc;
        in_valid   = 1'b1;
        in_data    = 32'hdeadbeef;
        out_ready  = 1'b1;
        in_valid0  = 1'b0;
        in_data0   = '0;
        out_ready0 = 1'b1;

        // Test 1: reset behaviour
        step();
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), 0);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_out_bit", W'(out_bit), 0);
        check("rst_out_last", W'(out_last), 0);
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", W'(in_ready), 1);
        check("post_rst_out_valid", W'(out_valid), 0);
        step();

        // Test 2: plain word, no backpressure, latency 1
        load1(32'h12345678, 1'b0);
        @(negedge clk);
        check("latency1_valid", W'(out_valid), 1);
        check("first_bit", W'(out_bit), 0);
        drain();

        // Test 3: out_ready toggling every cycle
        load1(32'h98765432, 1'b0);
        for (int i = 0; i < 64; i++) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        drain();

        // Test 4: back-to-back words, no bubble
        push1(32'hffeeddcc);
        push1(32'hbbaa9988);
        in_valid = 1'b1;
        in_data  = 32'hffeeddcc;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        check("b2b_first_accept", W'(acc), 1);
        in_data = 32'hbbaa9988;
        vcount  = 0;
        mism    = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
            if (in_ready !== ((i == 31 || i == 63) ? 1'b1 : 1'b0)) mism++;
            acc = in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        check("b2b_valid_cycles", W'(vcount), 64);
        check("b2b_ready_only_last", W'(mism), 0);
        drain();

        // Test 5: reset after 10 bits, then a fresh word
        load1(32'h77665544, 1'b0);
        repeat (10) step();
        reset     = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        word_q.delete();
        step();
        @(negedge clk);
        check("midrst_out_valid", W'(out_valid), 0);
        check("midrst_out_last", W'(out_last), 0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        load1(32'h33221100, 1'b0);
        drain();

        // Test 6: LSB-first instance, word 1
        for (int i = 0; i < W; i++) exp0_q.push_back(ebit(32'h00000001, 1'b0, i));
        in_valid0 = 1'b1;
        in_data0  = 32'h00000001;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready0;
            step();
            n++;
        end while (!acc && n < 50);
        in_valid0 = 1'b0;
        check("lsb_accept", W'(acc), 1);
        @(negedge clk);
        check("lsb_first_bit", W'(out_bit0), 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
